// File: rtl/distribute_1xn_dst_tag_seq_pkg.sv
// Shared widths and helpers for the 1xN destination-tag distribution stage.
// Compile-time option DISTRIBUTE_MULTICAST_EN is consumed by the interface and top, not here.
package distribute_pkg;

  localparam int DROP_CNT_WIDTH = 16;
  localparam int MAX_NUM_OUT    = 256;

  function automatic int next_cmd_width(input int in_w, input int tag_w);
    return ((in_w - tag_w) > 1) ? (in_w - tag_w) : 1;
  endfunction

  // Callers truncate the result to their own output count.
  function automatic logic [MAX_NUM_OUT-1:0] tag_onehot(input int unsigned tag);
    return MAX_NUM_OUT'(1) << tag;
  endfunction

endpackage

// File: rtl/distribute_1xn_dst_tag_seq_if.sv
// Input/output bus bundle for distribute_1xn_dst_tag_seq.
// DISTRIBUTE_MULTICAST_EN adds i_mcast / i_mcast_mask to the bundle.
interface distribute_1xn_dst_tag_seq_if
  import distribute_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int DESTINATION_TAG_WIDTH = 2,
  parameter int IN_COMMAND_WIDTH      = 4
);
  localparam int NUM_DATA_OUT      = 2 ** DESTINATION_TAG_WIDTH;
  localparam int NEXT_CMD_WIDTH    = next_cmd_width(IN_COMMAND_WIDTH, DESTINATION_TAG_WIDTH);
  localparam int OUT_COMMAND_WIDTH = NUM_DATA_OUT * NEXT_CMD_WIDTH;

  logic                               i_valid;
  logic                               o_ready;
  logic [DATA_WIDTH-1:0]              i_data_bus;
  logic [IN_COMMAND_WIDTH-1:0]        i_cmd;
  logic [NUM_DATA_OUT-1:0]            o_valid;
  logic [NUM_DATA_OUT-1:0]            i_ready;
  logic [NUM_DATA_OUT*DATA_WIDTH-1:0] o_data_bus;
  logic [OUT_COMMAND_WIDTH-1:0]       o_cmd;
`ifdef DISTRIBUTE_MULTICAST_EN
  logic                               i_mcast;
  logic [NUM_DATA_OUT-1:0]            i_mcast_mask;
`endif

  modport slave (
`ifdef DISTRIBUTE_MULTICAST_EN
    input  i_mcast, i_mcast_mask,
`endif
    input  i_valid, i_data_bus, i_cmd, i_ready,
    output o_ready, o_valid, o_data_bus, o_cmd
  );

  modport master (
`ifdef DISTRIBUTE_MULTICAST_EN
    output i_mcast, i_mcast_mask,
`endif
    output i_valid, i_data_bus, i_cmd, i_ready,
    input  o_ready, o_valid, o_data_bus, o_cmd
  );

endinterface

// File: rtl/distribute_1xn_dst_tag_seq_out_slice.sv
// One-entry valid/ready register slice holding a data word and its forwarded command.
// A reload in the same cycle as a drain takes priority, keeping the slot full.
module distribute_out_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CMD_WIDTH-1:0]  cmd_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic                  free_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CMD_WIDTH-1:0]  cmd_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [CMD_WIDTH-1:0]  cmd_q,   cmd_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      cmd_d   = cmd_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cmd_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
    end
  end

  // Pass-through ready: a slot draining this cycle can accept a new word.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cmd_o   = cmd_q;

endmodule

// File: rtl/distribute_1xn_dst_tag_seq.sv
// Registered 1-to-N distribution switch steered by the top command bits (destination tag).
// DISTRIBUTE_MULTICAST_EN enables mask-based multicast and the empty-set drop counter.
module distribute_1xn_dst_tag_seq
  import distribute_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int DESTINATION_TAG_WIDTH = 2,
  parameter int IN_COMMAND_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  distribute_1xn_dst_tag_seq_if.slave bus,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt
);

  localparam int NUM_DATA_OUT   = 2 ** DESTINATION_TAG_WIDTH;
  localparam int NEXT_CMD_WIDTH = next_cmd_width(IN_COMMAND_WIDTH, DESTINATION_TAG_WIDTH);

  if (IN_COMMAND_WIDTH < DESTINATION_TAG_WIDTH) begin : g_bad_cfg
    $error("IN_COMMAND_WIDTH must be >= DESTINATION_TAG_WIDTH");
  end

  logic [DESTINATION_TAG_WIDTH-1:0] tag;
  logic [NEXT_CMD_WIDTH-1:0]        next_cmd;
  logic [NUM_DATA_OUT-1:0]          dest;
  logic [NUM_DATA_OUT-1:0]          slot_free;
  logic [NUM_DATA_OUT-1:0]          slot_vld;
  logic [NUM_DATA_OUT-1:0]          load;
  logic                             ready;
  logic                             accept;

  assign tag = bus.i_cmd[IN_COMMAND_WIDTH-1 -: DESTINATION_TAG_WIDTH];

  // The final stage of a tree has no command bits left to forward.
  if (IN_COMMAND_WIDTH > DESTINATION_TAG_WIDTH) begin : g_next_cmd
    assign next_cmd = bus.i_cmd[NEXT_CMD_WIDTH-1:0];
  end else begin : g_last_stage
    assign next_cmd = '0;
  end

`ifdef DISTRIBUTE_MULTICAST_EN
  assign dest = bus.i_mcast ? bus.i_mcast_mask
                            : NUM_DATA_OUT'(tag_onehot(32'(tag)));
`else
  assign dest = NUM_DATA_OUT'(tag_onehot(32'(tag)));
`endif

  // All targeted slots must be free so a multicast is never split across cycles.
  assign ready  = i_en && !rst && (&(slot_free | ~dest));
  assign accept = bus.i_valid && ready;
  assign load   = accept ? dest : '0;

  assign bus.o_ready = ready;
  assign bus.o_valid = slot_vld;

  for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_slot
    distribute_out_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .CMD_WIDTH  (NEXT_CMD_WIDTH)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (bus.i_data_bus),
      .cmd_i   (next_cmd),
      .ready_i (bus.i_ready[k]),
      .valid_o (slot_vld[k]),
      .free_o  (slot_free[k]),
      .data_o  (bus.o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .cmd_o   (bus.o_cmd[k*NEXT_CMD_WIDTH +: NEXT_CMD_WIDTH])
    );
  end

`ifdef DISTRIBUTE_MULTICAST_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of accepted words whose mask selected no output.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && (dest == '0) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_distribute_1xn_dst_tag_seq.sv
// Scoreboard bench for distribute_1xn_dst_tag_seq: directed scenarios, then random traffic.
// Honours DISTRIBUTE_MULTICAST_EN when the design is built with it.
module tb_distribute_1xn_dst_tag_seq;
  import distribute_pkg::*;

  localparam int DW = 32, DTW = 2, ICW = 4, N = 4, NCW = 2;

  typedef struct {
    logic [DW-1:0]  d;
    logic [NCW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0;
  logic rst6 = 1'b1, en6 = 1'b0;
  logic [15:0] drop_cnt, drop_cnt6;
  int n_cmp = 0, n_err = 0;

  ent_t        sbq [N][$];
  int unsigned drop_m = 0;

  distribute_1xn_dst_tag_seq_if #(.DATA_WIDTH(DW), .DESTINATION_TAG_WIDTH(DTW),
                                  .IN_COMMAND_WIDTH(ICW)) bus ();
  distribute_1xn_dst_tag_seq_if #(.DATA_WIDTH(DW), .DESTINATION_TAG_WIDTH(DTW),
                                  .IN_COMMAND_WIDTH(2)) bus6 ();

  distribute_1xn_dst_tag_seq #(.DATA_WIDTH(DW), .DESTINATION_TAG_WIDTH(DTW),
                               .IN_COMMAND_WIDTH(ICW)) dut (
    .clk(clk), .rst(rst), .i_en(en), .bus(bus), .o_drop_cnt(drop_cnt));

  distribute_1xn_dst_tag_seq #(.DATA_WIDTH(DW), .DESTINATION_TAG_WIDTH(DTW),
                               .IN_COMMAND_WIDTH(2)) dut6 (
    .clk(clk), .rst(rst6), .i_en(en6), .bus(bus6), .o_drop_cnt(drop_cnt6));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares outputs against the model state, then advances the model.
  always @(negedge clk) begin
    logic [N-1:0] d, vexp;
    logic         rexp;
    ent_t         e;
    for (int k = 0; k < N; k++) vexp[k] = (sbq[k].size() != 0);
    chk("o_valid", bus.o_valid, vexp);
    for (int k = 0; k < N; k++) begin
      if (sbq[k].size() != 0) begin
        chk("o_data", bus.o_data_bus[k*DW +: DW], sbq[k][0].d);
        chk("o_cmd", bus.o_cmd[k*NCW +: NCW], sbq[k][0].c);
      end
    end
    d = 4'(1) << (bus.i_cmd >> (ICW - DTW));
`ifdef DISTRIBUTE_MULTICAST_EN
    if (bus.i_mcast) d = bus.i_mcast_mask;
`endif
    rexp = en && !rst;
    for (int k = 0; k < N; k++)
      if (d[k] && sbq[k].size() != 0 && !bus.i_ready[k]) rexp = 1'b0;
    chk("o_ready", bus.o_ready, rexp);
    chk("o_drop_cnt", drop_cnt, drop_m);
    if (rst) begin
      for (int k = 0; k < N; k++) sbq[k].delete();
      drop_m = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (sbq[k].size() != 0 && bus.i_ready[k]) void'(sbq[k].pop_front());
      if (bus.i_valid && rexp) begin
        if (d == 0 && drop_m < 65535) drop_m++;
        e.d = bus.i_data_bus;
        e.c = NCW'(bus.i_cmd % (1 << NCW));
        for (int k = 0; k < N; k++) if (d[k]) sbq[k].push_back(e);
      end
    end
  end

  initial begin
    logic [DW-1:0] w2;
    logic          acc;
    int            total;
    logic [15:0]   dc;

    bus.i_valid = 1'b1; bus.i_cmd = 4'b1011; bus.i_data_bus = 32'h1234_5678;
    bus.i_ready = '0; en = 1'b1;
    bus6.i_valid = 1'b0; bus6.i_cmd = '0; bus6.i_data_bus = '0; bus6.i_ready = '0;
`ifdef DISTRIBUTE_MULTICAST_EN
    bus.i_mcast = 1'b0; bus.i_mcast_mask = '0;
    bus6.i_mcast = 1'b0; bus6.i_mcast_mask = '0;
`endif

    // Reset held with a valid word pending
    step(); step();
    chk("rst_o_ready", bus.o_ready, 1'b0);
    chk("rst_o_valid", bus.o_valid, 4'b0000);
    chk("rst_o_data", bus.o_data_bus, 128'h0);
    chk("rst_o_cmd", bus.o_cmd, 8'h0);
    chk("rst_drop", drop_cnt, 16'h0);

    // Unicast to tag 2, then streaming
    rst = 1'b0; bus.i_ready = 4'b1111; bus.i_data_bus = 32'hAAAA_AAAA;
    #1 chk("uni_ready", bus.o_ready, 1'b1);
    step();
    chk("uni_valid", bus.o_valid, 4'b0100);
    chk("uni_data2", bus.o_data_bus[95:64], 32'hAAAA_AAAA);
    chk("uni_cmd2", bus.o_cmd[5:4], 2'b11);
    for (int i = 0; i < 3; i++) begin
      bus.i_data_bus = $urandom; bus.i_cmd = 4'b1000 | 4'($urandom_range(0, 3));
      #1 chk("stream_ready", bus.o_ready, 1'b1);
      step();
      chk("stream_valid", bus.o_valid, 4'b0100);
    end
    bus.i_valid = 1'b0;
    step();

    // Backpressure on slot 2
    bus.i_ready = 4'b1011; bus.i_valid = 1'b1; bus.i_cmd = 4'b1001; bus.i_data_bus = $urandom;
    #1 chk("bp_first_ready", bus.o_ready, 1'b1);
    step();
    w2 = $urandom; bus.i_cmd = 4'b1010; bus.i_data_bus = w2;
    #1 chk("bp_second_blocked", bus.o_ready, 1'b0);
    step();
    chk("bp_still_blocked", bus.o_ready, 1'b0);
    bus.i_cmd = 4'b0111; bus.i_data_bus = $urandom;
    #1 chk("bp_other_tag_ready", bus.o_ready, 1'b1);
    step();
    bus.i_cmd = 4'b1010; bus.i_data_bus = w2;
    #1 chk("bp_reblocked", bus.o_ready, 1'b0);
    bus.i_ready = 4'b1111;
    #1 chk("bp_released", bus.o_ready, 1'b1);
    step();
    chk("bp_second_loaded", bus.o_data_bus[95:64], w2);

    // Enable gating while a slot drains
    bus.i_ready = 4'b0111; bus.i_cmd = 4'b1100; bus.i_data_bus = $urandom;
    #1 step();
    en = 1'b0; bus.i_cmd = 4'b1101; bus.i_data_bus = $urandom;
    #1 chk("en_off_ready", bus.o_ready, 1'b0);
    step();
    chk("en_off_pending", bus.o_valid, 4'b1000);
    bus.i_ready = 4'b1111;
    step();
    chk("en_off_drained", bus.o_valid, 4'b0000);
    en = 1'b1;
    #1 chk("en_on_ready", bus.o_ready, 1'b1);
    step();
    chk("en_on_loaded", bus.o_valid, 4'b1000);
    bus.i_valid = 1'b0;
    step();

`ifdef DISTRIBUTE_MULTICAST_EN
    // Multicast blocked by one busy slot, then delivered atomically
    bus.i_ready = 4'b1110; bus.i_valid = 1'b1; bus.i_cmd = 4'b0000; bus.i_data_bus = $urandom;
    #1 step();
    bus.i_mcast = 1'b1; bus.i_mcast_mask = 4'b1011; bus.i_data_bus = 32'hBBBB_BBBB;
    #1 chk("mc_blocked", bus.o_ready, 1'b0);
    step();
    bus.i_ready = 4'b1111;
    #1 chk("mc_ready", bus.o_ready, 1'b1);
    step();
    chk("mc_valid", bus.o_valid, 4'b1011);
    chk("mc_data0", bus.o_data_bus[31:0], 32'hBBBB_BBBB);
    chk("mc_data1", bus.o_data_bus[63:32], 32'hBBBB_BBBB);
    chk("mc_data3", bus.o_data_bus[127:96], 32'hBBBB_BBBB);
    dc = drop_cnt; bus.i_mcast_mask = 4'b0000;
    #1 chk("mc_empty_ready", bus.o_ready, 1'b1);
    step();
    chk("mc_drop_inc", drop_cnt, dc + 16'd1);
    bus.i_valid = 1'b0; bus.i_mcast = 1'b0;
    step();
`endif

    // Random traffic with AXI-style hold of unaccepted words
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = bus.i_valid && bus.o_ready;
      step();
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      bus.i_ready = 4'($urandom) | 4'($urandom);
      if (!bus.i_valid || acc) begin
        bus.i_valid = ($urandom_range(0, 3) != 0);
        bus.i_data_bus = $urandom;
        bus.i_cmd = 4'($urandom);
`ifdef DISTRIBUTE_MULTICAST_EN
        bus.i_mcast = ($urandom_range(0, 2) == 0);
        bus.i_mcast_mask = 4'($urandom);
`endif
      end
    end
    rst = 1'b0; en = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 4'b1111;
    step(); step(); step();
    total = 0;
    for (int k = 0; k < N; k++) total += sbq[k].size();
    chk("drain_empty", 32'(total), 32'd0);
    chk("drain_o_valid", bus.o_valid, 4'b0000);

    // Last-stage instance: no forwarded command bits
    rst6 = 1'b0; en6 = 1'b1;
    step();
    bus6.i_valid = 1'b1; bus6.i_cmd = 2'b01; bus6.i_data_bus = 32'hC0DE_0001;
    #1 chk("last_ready", bus6.o_ready, 1'b1);
    step();
    bus6.i_valid = 1'b0;
    chk("last_valid", bus6.o_valid, 4'b0010);
    chk("last_cmd", bus6.o_cmd, 4'b0000);
    chk("last_data1", bus6.o_data_bus[63:32], 32'hC0DE_0001);
    rst6 = 1'b1;
    step();
    chk("last_rst_valid", bus6.o_valid, 4'b0000);
    chk("last_rst_data", bus6.o_data_bus, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
